time_set_ctrl: RTL

- Front-panel edit controller sitting directly upstream of the cascaded digit counters (counter3 and its siblings); drives their set/setValue inputs.
- Debounces two raw push-buttons (MODE, INC) and walks an edit cursor across NUM_FIELDS 4-bit digit fields, most-significant first.
- Holds the selected counter in load (set high) with an incrementable, wrap-limited value.
- In RUN mode all counters free-run untouched.

---
 rtl/time_pkg.sv | 18 +
 rtl/btn_debounce.sv | 40 ++++
 rtl/time_set_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared types and helpers for the front-panel time edit controller.
package time_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      EDIT = 1'b1
   } state_e;

   localparam int DIGIT_W    = 4;
   localparam int MAX_FIELDS = 8;

   // Wrap limit of field k, taken from a packed nibble table (zero-extended to 32 bits).
   function automatic logic [DIGIT_W-1:0] field_max(input logic [4*MAX_FIELDS-1:0] fmax,
                                                    input logic [2:0]              k);
      return fmax[{k, 2'b00} +: DIGIT_W];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter and
// a single-cycle pulse on each accepted press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;

   // Synchronize, then accept a new level only after an unbroken run of differing samples.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_o <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         pulse_o <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
            pulse_o <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel edit controller: MODE walks a cursor over the digit fields (MSB first),
// INC bumps the held value, and the selected counter is kept in load via set/set_value.
module time_set_ctrl
   import time_pkg::*;
#(
   parameter int                            NUM_FIELDS      = 4,
   parameter logic [DIGIT_W*NUM_FIELDS-1:0] FIELD_MAX       = 16'h3959,
   parameter int                            DEBOUNCE_CYCLES = 250000,
   parameter int                            BLINK_CYCLES    = 12500000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            btn_mode,
   input  logic                            btn_inc,
   input  logic [DIGIT_W*NUM_FIELDS-1:0]   field_q,
   output logic [NUM_FIELDS-1:0]           set,
   output logic [DIGIT_W-1:0]              set_value,
   output logic                            edit_active,
   output logic [$clog2(NUM_FIELDS)-1:0]   edit_field,
   output logic                            blink
);

   localparam int KW  = $clog2(NUM_FIELDS);
   localparam int BCW = $clog2(BLINK_CYCLES + 1);
   localparam logic [4*MAX_FIELDS-1:0] FMAX_EXT = (4*MAX_FIELDS)'(FIELD_MAX);

   state_e             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic [DIGIT_W-1:0] val_q, val_d;
   logic [DIGIT_W-1:0] nib_s, max_s;
   logic [BCW-1:0]     bcnt_q, bcnt_d;
   logic               blink_d;
   logic               mode_pulse_s, inc_pulse_s;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .clk_i   (clk),
      .rst_i   (reset),
      .btn_i   (btn_mode),
      .pulse_o (mode_pulse_s)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
      .clk_i   (clk),
      .rst_i   (reset),
      .btn_i   (btn_inc),
      .pulse_o (inc_pulse_s)
   );

   // Cursor/value next state; MODE has priority so a coincident INC is dropped.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      val_d   = val_q;
      nib_s   = '0;
      max_s   = field_max(FMAX_EXT, 3'(k_q));
      if (mode_pulse_s) begin
         if (state_q == RUN) begin
            state_d = EDIT;
            k_d     = KW'(NUM_FIELDS - 1);
         end else if (k_q != '0) begin
            k_d = k_q - KW'(1);
         end else begin
            state_d = RUN;
            k_d     = '0;
         end
         nib_s = field_q[DIGIT_W*int'(k_d) +: DIGIT_W];
         max_s = field_max(FMAX_EXT, 3'(k_d));
         // An out-of-range counter value is never offered back for loading.
         if ((state_d == EDIT) && (nib_s <= max_s)) begin
            val_d = nib_s;
         end else begin
            val_d = '0;
         end
      end else if (inc_pulse_s && (state_q == EDIT)) begin
         val_d = (val_q >= max_s) ? '0 : val_q + DIGIT_W'(1);
      end else begin
         val_d = val_q;
      end
   end

   // Blink phase restarts on every cursor move so each field starts visible.
   always_comb begin
      bcnt_d  = bcnt_q;
      blink_d = blink;
      if (mode_pulse_s || (state_q == RUN)) begin
         bcnt_d  = '0;
         blink_d = 1'b0;
      end else if (bcnt_q == BCW'(BLINK_CYCLES - 1)) begin
         bcnt_d  = '0;
         blink_d = ~blink;
      end else begin
         bcnt_d  = bcnt_q + BCW'(1);
         blink_d = blink;
      end
   end

   // State and outputs share one edge, so set never rises with a stale set_value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         k_q         <= '0;
         val_q       <= '0;
         bcnt_q      <= '0;
         set         <= '0;
         set_value   <= '0;
         edit_active <= 1'b0;
         edit_field  <= '0;
         blink       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         val_q       <= val_d;
         bcnt_q      <= bcnt_d;
         set         <= (state_d == EDIT) ? (NUM_FIELDS'(1) << k_d) : '0;
         set_value   <= val_d;
         edit_active <= (state_d == EDIT);
         edit_field  <= k_d;
         blink       <= blink_d;
      end
   end

endmodule
